// File: rtl/ram64_core.sv
// ram64_core: 64 x 16-bit memory, one synchronous write port and one
// combinational read port. Organised as eight 8-word banks: address[5:3]
// picks the bank, address[2:0] picks the word inside that bank.
// Optional feature macro: RAM64_BYPASS_EN -- when defined, write data is
// forwarded combinationally to `out` while load=1 (suppressed in reset).
// Reset (rst_n, async, active-low) clears every word.

module ram64_core (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] out,
  input  logic [15:0] in,
  input  logic [5:0]  address,
  input  logic        load
);

  // Storage: word_r[bank][word]
  logic [15:0] word_r [0:7][0:7];

  logic [2:0]  bank_sel_s;
  logic [2:0]  word_sel_s;
  logic [7:0]  bank_we_s;
  logic [15:0] bank_rd_s [0:7];
  logic [15:0] mem_rd_s;

  // One-hot decode of a 3-bit bank index into per-bank enables.
  function automatic logic [7:0] bank_decode(input logic [2:0] sel);
    logic [7:0] onehot;
    case (sel)
      3'd0:    onehot = 8'b0000_0001;
      3'd1:    onehot = 8'b0000_0010;
      3'd2:    onehot = 8'b0000_0100;
      3'd3:    onehot = 8'b0000_1000;
      3'd4:    onehot = 8'b0001_0000;
      3'd5:    onehot = 8'b0010_0000;
      3'd6:    onehot = 8'b0100_0000;
      3'd7:    onehot = 8'b1000_0000;
      default: onehot = 8'b0000_0000;
    endcase
    return onehot;
  endfunction

  assign bank_sel_s = address[5:3];
  assign word_sel_s = address[2:0];

  // Bank write enables: exactly one bank enabled when load is high.
  always_comb begin
    bank_we_s = 8'h00;
    if (load) begin
      bank_we_s = bank_decode(bank_sel_s);
    end else begin
      bank_we_s = 8'h00;
    end
  end

  // Word storage: async clear, otherwise write the addressed word only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 8; b++) begin
        for (int w = 0; w < 8; w++) begin
          word_r[b][w] <= 16'h0000;
        end
      end
    end else begin
      for (int b = 0; b < 8; b++) begin
        for (int w = 0; w < 8; w++) begin
          if (bank_we_s[b] && (word_sel_s == 3'(w))) begin
            word_r[b][w] <= in;
          end
        end
      end
    end
  end

  // Per-bank read: each bank presents the word selected by address[2:0].
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      bank_rd_s[b] = word_r[b][word_sel_s];
    end
  end

  // 8:1 bank output mux on address[5:3].
  always_comb begin
    mem_rd_s = 16'h0000;
    case (bank_sel_s)
      3'd0:    mem_rd_s = bank_rd_s[0];
      3'd1:    mem_rd_s = bank_rd_s[1];
      3'd2:    mem_rd_s = bank_rd_s[2];
      3'd3:    mem_rd_s = bank_rd_s[3];
      3'd4:    mem_rd_s = bank_rd_s[4];
      3'd5:    mem_rd_s = bank_rd_s[5];
      3'd6:    mem_rd_s = bank_rd_s[6];
      3'd7:    mem_rd_s = bank_rd_s[7];
      default: mem_rd_s = 16'h0000;
    endcase
  end

  // Output select: stored word, or forwarded write data when bypass is built in.
  always_comb begin
    out = mem_rd_s;
`ifdef RAM64_BYPASS_EN
    if (load && rst_n) begin
      out = in;
    end else begin
      out = mem_rd_s;
    end
`else
    out = mem_rd_s;
`endif
  end

endmodule

// File: tb/tb_ram64_core.sv
// Self-checking bench for ram64_core. Stimulus pushes expected values into a
// scoreboard queue; a monitor on the falling clock edge pops and compares.

module tb_ram64_core;

  logic        clk;
  logic        rst_n;
  logic [15:0] out;
  logic [15:0] in;
  logic [5:0]  address;
  logic        load;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run;
  int   tests_failed;

  ram64_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .out     (out),
    .in      (in),
    .address (address),
    .load    (load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare out against every expectation queued this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      tests_run = tests_run + 1;
      if (out !== e.exp) begin
        tests_failed = tests_failed + 1;
        $display("FAIL %s: out=%h expected=%h", e.name, out, e.exp);
      end
    end
  end

  task automatic drive(input logic [5:0] a, input logic [15:0] d, input logic ld);
    @(posedge clk);
    #1;
    address = a;
    in      = d;
    load    = ld;
  endtask

  task automatic expect_out(input string nm, input logic [15:0] v);
    exp_t e;
    e.name = nm;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rdw_exp;
    int          wait_cyc;
    tests_run    = 0;
    tests_failed = 0;
    rst_n   = 1'b0;
    load    = 1'b0;
    in      = 16'h0000;
    address = 6'd0;

    // Reset state
    drive(6'd32, 16'h0000, 1'b0);
    expect_out("reset_out", 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic write/readback
    drive(6'd32, 16'h0001, 1'b1);
    drive(6'd32, 16'h0001, 1'b0);
    expect_out("basic_rd32", 16'h0001);

    // Unwritten read, load=0 must not write
    drive(6'd9, 16'h0003, 1'b0);
    expect_out("unwritten_rd9", 16'h0000);
    drive(6'd9, 16'h0003, 1'b0);
    expect_out("unwritten_rd9_hold", 16'h0000);

    // Multiple writes
    drive(6'd50, 16'h0007, 1'b1);
    drive(6'd27, 16'h000F, 1'b1);
    drive(6'd60, 16'h001F, 1'b1);
    drive(6'd63, 16'h00FF, 1'b1);
    drive(6'd50, 16'h0000, 1'b0); expect_out("multi_rd50", 16'h0007);
    drive(6'd27, 16'h0000, 1'b0); expect_out("multi_rd27", 16'h000F);
    drive(6'd60, 16'h0000, 1'b0); expect_out("multi_rd60", 16'h001F);
    drive(6'd63, 16'h0000, 1'b0); expect_out("multi_rd63", 16'h00FF);
    drive(6'd32, 16'h0000, 1'b0); expect_out("multi_rd32", 16'h0001);
    drive(6'd45, 16'h0000, 1'b0); expect_out("multi_rd45", 16'h0000);
    drive(6'd6,  16'h0000, 1'b0); expect_out("multi_rd6",  16'h0000);
    drive(6'd9,  16'h0000, 1'b0); expect_out("multi_rd9",  16'h0000);

    // Bank isolation: same low bits, different banks
    drive(6'd8, 16'hAAAA, 1'b1);
    drive(6'd0, 16'h5555, 1'b1);
    drive(6'd8, 16'h0000, 1'b0); expect_out("bank_rd8", 16'hAAAA);
    drive(6'd0, 16'h0000, 1'b0); expect_out("bank_rd0", 16'h5555);
    drive(6'd16, 16'h0000, 1'b0); expect_out("bank_rd16", 16'h0000);

    // Read-during-write at address 27 (holds 000F)
`ifdef RAM64_BYPASS_EN
    rdw_exp = 16'h1234;
`else
    rdw_exp = 16'h000F;
`endif
    drive(6'd27, 16'h1234, 1'b1);
    expect_out("rdw_before_edge", rdw_exp);
    drive(6'd27, 16'h0000, 1'b0);
    expect_out("rdw_after_edge", 16'h1234);

    // Reset during operation: mid-cycle, load=1, in=FFFF
    drive(6'd27, 16'hFFFF, 1'b1);
    #2;
    rst_n = 1'b0;
    expect_out("rst_mid_out", 16'h0000);
    @(posedge clk);
    #1;
    expect_out("rst_load_ignored", 16'h0000);
    load = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < 64; a++) begin
      drive(6'(a), 16'h0000, 1'b0);
      expect_out($sformatf("rst_clr_%0d", a), 16'h0000);
    end

    // Write after reset release resumes normally
    drive(6'd63, 16'hBEEF, 1'b1);
    drive(6'd63, 16'h0000, 1'b0);
    expect_out("post_rst_rd63", 16'hBEEF);

    // Drain scoreboard with a bounded wait
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      tests_run    = tests_run + 1;
      tests_failed = tests_failed + 1;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
